div_iter_unit: RTL and testbench

//   Parametrised iterative radix-2 divider that replaces the separate signed/unsigned divider IP pair
//   (div/divu) beside mycpu_top with one block.

---
 rtl/div_iter_unit.sv | 113 +++++++++++
 tb/tb_div_iter_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for signed (div) and unsigned (divu) requests.
// One quotient bit per cycle, a sign-fixup cycle, then the result is held until the consumer takes it.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_signed,
  input  logic [WIDTH-1:0] s_dividend,
  input  logic [WIDTH-1:0] s_divisor,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quotient,
  output logic [WIDTH-1:0] m_remainder,
  output logic [TAG_W-1:0] m_tag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] prem;   // partial remainder, always < divisor between steps
  logic [WIDTH-1:0] dq;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic             q_neg, r_neg;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign s_ready = (state == IDLE) && !flush;
  assign busy    = (state != IDLE);

  assign shifted = {prem, dq[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign a_abs   = (s_signed && s_dividend[WIDTH-1]) ? -s_dividend : s_dividend;
  assign b_abs   = (s_signed && s_divisor[WIDTH-1])  ? -s_divisor  : s_divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      m_valid     <= 1'b0;
      m_quotient  <= '0;
      m_remainder <= '0;
      m_tag       <= '0;
      cnt         <= '0;
      prem        <= '0;
      dq          <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      tag_q       <= '0;
    end else if (flush) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            if (s_divisor == '0) begin
              m_quotient  <= '1;
              m_remainder <= s_dividend;
              m_tag       <= s_tag;
              m_valid     <= 1'b1;
              state       <= DONE;
            end else begin
              prem  <= '0;
              dq    <= a_abs;
              dvs   <= b_abs;
              q_neg <= s_signed & (s_dividend[WIDTH-1] ^ s_divisor[WIDTH-1]);
              r_neg <= s_signed & s_dividend[WIDTH-1];
              tag_q <= s_tag;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          // trial[WIDTH] set means the subtraction went negative: restore
          prem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dq   <= {dq[WIDTH-2:0], ~trial[WIDTH]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          // MIN / -1 lands on MIN here without special handling
          m_quotient  <= q_neg ? -dq : dq;
          m_remainder <= r_neg ? -prem : prem;
          m_tag       <= tag_q;
          m_valid     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed corner cases at WIDTH=32 plus
// random traffic at WIDTH=32 and WIDTH=8 against a plain-arithmetic division model.
module tb_div_iter_unit;
  localparam int W  = 32;
  localparam int W8 = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 32-bit DUT ----------------
  logic          reset, flush, s_valid, s_signed, m_ready = 1'b0;
  logic [W-1:0]  s_dividend, s_divisor;
  logic [TW-1:0] s_tag;
  logic          s_ready, m_valid, busy;
  logic [W-1:0]  m_quotient, m_remainder;
  logic [TW-1:0] m_tag;
  bit            rand_ready = 0, ready_force = 0;

  div_iter_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_signed(s_signed),
    .s_dividend(s_dividend), .s_divisor(s_divisor), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_quotient(m_quotient),
    .m_remainder(m_remainder), .m_tag(m_tag), .busy(busy));

  // ---------------- 8-bit DUT ----------------
  logic          reset8, flush8, s_valid8, s_signed8, m_ready8 = 1'b0;
  logic [W8-1:0] s_dividend8, s_divisor8;
  logic [TW-1:0] s_tag8;
  logic          s_ready8, m_valid8, busy8;
  logic [W8-1:0] m_quotient8, m_remainder8;
  logic [TW-1:0] m_tag8;
  bit            done8 = 0;

  div_iter_unit #(.WIDTH(W8), .TAG_W(TW)) dut8 (
    .clk(clk), .reset(reset8), .flush(flush8),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_signed(s_signed8),
    .s_dividend(s_dividend8), .s_divisor(s_divisor8), .s_tag(s_tag8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_quotient(m_quotient8),
    .m_remainder(m_remainder8), .m_tag(m_tag8), .busy(busy8));

  typedef struct {
    longint unsigned q;
    longint unsigned r;
    logic [TW-1:0]   tag;
  } exp_t;
  exp_t sbq[$], sbq8[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: truncating division on w-bit values, divide-by-zero gives all ones / dividend.
  function automatic void ref_div(input int w, input bit sgn, input longint unsigned a,
                                  input longint unsigned b, output longint unsigned q,
                                  output longint unsigned r);
    longint unsigned mask = (64'd1 << w) - 1;
    longint sa, sb;
    if (b == 0) begin
      q = mask; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q = longint'(sa / sb) & mask;
      r = longint'(sa % sb) & mask;
    end
  endfunction

  function automatic logic [W-1:0] pick32();
    case ($urandom_range(0, 9))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [W8-1:0] pick8();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 8'h80;
      default: return W8'($urandom);
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    m_ready8 = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitors ----------------
  logic [2*W+TW-1:0] held;
  bit   stalled = 0;
  exp_t e, e8;

  always @(negedge clk) begin
    if (reset || flush) stalled = 0;
    else begin
      if (stalled && m_valid)
        chk("hold_stable", ({m_quotient, m_remainder, m_tag} == held), 1);
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) chk("spurious_result", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("quotient", m_quotient, e.q);
          chk("remainder", m_remainder, e.r);
          chk("tag", m_tag, e.tag);
        end
      end
      stalled = m_valid && !m_ready;
      held    = {m_quotient, m_remainder, m_tag};
    end
  end

  always @(negedge clk) begin
    if (!reset8 && m_valid8 && m_ready8) begin
      if (sbq8.size() == 0) chk("spurious_result8", 1, 0);
      else begin
        e8 = sbq8.pop_front();
        chk("quotient8", m_quotient8, e8.q);
        chk("remainder8", m_remainder8, e8.r);
        chk("tag8", m_tag8, e8.tag);
      end
    end
  end

  // ---------------- 32-bit drivers ----------------
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int acc);
    longint unsigned q, r;
    int n = 0;
    acc = -1;
    @(posedge clk); #1;
    s_valid = 1; s_signed = sgn; s_dividend = a; s_divisor = b; s_tag = tag;
    @(negedge clk);
    while (!s_ready && n < 500) begin @(negedge clk); n++; end
    if (!s_ready) begin
      chk("accept_timeout", 0, 1);
      s_valid = 0;
      return;
    end
    acc = cyc + 1;
    ref_div(W, sgn, a, b, q, r);
    sbq.push_back('{q, r, tag});
    @(posedge clk); #1;
    s_valid = 0; s_signed = $urandom; s_dividend = $urandom; s_divisor = $urandom; s_tag = $urandom;
  endtask

  task automatic wait_valid(input int acc, output int lat);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    if (!m_valid) chk("valid_timeout", 0, 1);
    lat = cyc - acc;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !s_ready) && n < 2000) begin @(negedge clk); n++; end
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic directed(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input int exp_lat);
    int acc, lat, n = 0;
    ready_force = 0;
    issue(sgn, a, b, tag, acc);
    wait_valid(acc, lat);
    chk("latency", lat, exp_lat);
    repeat (10) begin
      chk("stall_m_valid", m_valid, 1);
      chk("stall_s_ready", s_ready, 0);
      @(negedge clk);
    end
    ready_force = 1;
    while (!(m_valid && m_ready) && n < 10) begin @(negedge clk); n++; end
    chk("hs_cycle_s_ready", s_ready, 0);
    @(negedge clk);
    chk("post_hs_m_valid", m_valid, 0);
    chk("post_hs_s_ready", s_ready, 1);
    ready_force = 0;
  endtask

  // ---------------- 8-bit random stream ----------------
  initial begin
    int n;
    bit sgn;
    logic [W8-1:0] a, b;
    logic [TW-1:0] tag;
    longint unsigned q, r;
    reset8 = 1; flush8 = 0; s_valid8 = 0; s_signed8 = 0;
    s_dividend8 = '0; s_divisor8 = '0; s_tag8 = '0;
    repeat (3) @(posedge clk);
    #1 reset8 = 0;
    for (int i = 0; i < 3000; i++) begin
      sgn = $urandom; a = pick8(); b = pick8(); tag = TW'($urandom);
      @(posedge clk); #1;
      s_valid8 = 1; s_signed8 = sgn; s_dividend8 = a; s_divisor8 = b; s_tag8 = tag;
      n = 0;
      @(negedge clk);
      while (!s_ready8 && n < 200) begin @(negedge clk); n++; end
      if (!s_ready8) begin chk("accept_timeout8", 0, 1); break; end
      ref_div(W8, sgn, a, b, q, r);
      sbq8.push_back('{q, r, tag});
      @(posedge clk); #1;
      s_valid8 = 0;
    end
    n = 0;
    while ((sbq8.size() != 0 || !s_ready8) && n < 500) begin @(negedge clk); n++; end
    chk("drain_empty8", sbq8.size(), 0);
    done8 = 1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc, seen, n;
    reset = 1; flush = 0; s_valid = 0; s_signed = 0;
    s_dividend = '0; s_divisor = '0; s_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_quotient", m_quotient, 0);
    chk("rst_remainder", m_remainder, 0);
    chk("rst_tag", m_tag, 0);

    directed(0, 32'd100, 32'd7, 4'h5, 33);
    directed(1, -32'sd7, 32'd2, 4'h1, 33);
    directed(1, 32'd7, -32'sd2, 4'h2, 33);
    directed(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h3, 33);
    directed(1, 32'h1234, 32'h0, 4'h6, 0);
    directed(0, 32'h1234, 32'h0, 4'h7, 0);

    // flush after five CALC steps drops the operation
    ready_force = 1;
    issue(0, 32'd12345, 32'd7, 4'h9, acc);
    repeat (5) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    chk("flush_cycle_s_ready", s_ready, 0);
    @(posedge clk); #1 flush = 0;
    sbq.delete();
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_m_valid", m_valid, 0);
    chk("flush_s_ready", s_ready, 1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (m_valid) seen++; end
    chk("flush_no_valid", seen, 0);
    issue(0, 32'd9, 32'd3, 4'hA, acc);
    drain();

    // random traffic with random consumer stalls
    rand_ready = 1;
    for (int i = 0; i < 1200; i++) begin
      issue($urandom, pick32(), pick32(), TW'($urandom), acc);
      if (acc < 0) break;
    end
    drain();
    rand_ready = 0;
    ready_force = 1;

    // reset in the middle of CALC clears all outputs
    issue(0, 32'd100, 32'd7, 4'hB, acc);
    drain();
    issue(0, 32'hDEAD_BEEF, 32'd3, 4'hC, acc);
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    sbq.delete();
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_quotient", m_quotient, 0);
    chk("midrst_remainder", m_remainder, 0);
    chk("midrst_tag", m_tag, 0);

    n = 0;
    while (!done8 && n < 60000) begin @(negedge clk); n++; end
    if (!done8) chk("width8_run_timeout", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
